uart_tx_queue: RTL and testbench

- Byte queue between the timelock controller and the UART transmitter.
- Accepts single-cycle byte pulses from the controller and buffers them in a FIFO.
- Drains bytes to the transmitter one at a time using its tx_ready / new-byte handshake.
- Lets the controller emit multi-byte responses, such as 92-nibble result dumps, without stalling on each byte.

---
 rtl/uart_tx_queue.sv | 124 ++++++++++++
 tb/tb_uart_tx_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO between the timelock controller and the UART transmitter
//
// Buffers single-cycle byte pulses from the controller and hands them to the
// UART transmitter one at a time, using its tx_ready / new-byte handshake.
//
// Ports:
//   clk          comm_clk domain clock, rising edge
//   rst          synchronous active-high reset
//   in_new_byte  one-cycle pulse, in_byte valid
//   in_byte      byte to enqueue
//   in_ready     FIFO not full
//   tx_ready     transmitter idle and able to take a byte
//   tx_new_byte  one-cycle pulse to the transmitter
//   tx_byte      byte to the transmitter, held until the next pulse
//   count        bytes stored, 0..2**DEPTH_LOG2
//   empty        count == 0
//   overflow     sticky, a byte was dropped on a full FIFO
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_new_byte,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  input  logic                  tx_ready,
  output logic                  tx_new_byte,
  output logic [7:0]            tx_byte,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACKWAIT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  full;
  logic                  do_deq;
  logic                  do_enq;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign in_ready = !full;

  // A byte arriving on a full FIFO is still accepted when a slot frees up
  // in the same cycle.
  assign do_enq = in_new_byte && (!full || do_deq);

  // Drain FSM. Dequeue decisions use the pre-edge count, so a byte written
  // into an empty FIFO is only issued on the following edge.
  always_comb begin
    state_next = state;
    do_deq     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          do_deq     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = ACKWAIT;
      end
      ACKWAIT: begin
        // tx_ready still high means the transmitter has not latched the byte.
        if (!tx_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_new_byte <= 1'b0;
      tx_byte     <= 8'h00;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      tx_new_byte <= do_deq;
      if (do_deq) begin
        tx_byte <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (do_enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (in_new_byte && !do_enq) begin
        overflow <= 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= in_byte;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - scoreboard bench for uart_tx_queue
//
// Two instances: dut_a with the default 16-entry FIFO and dut_b with a
// 128-entry FIFO for controller-style response traffic.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_new_byte_a = 1'b0;
  logic [7:0] in_byte_a = 8'h00;
  logic       in_ready_a;
  logic       tx_ready_a;
  logic       tx_new_byte_a;
  logic [7:0] tx_byte_a;
  logic [4:0] count_a;
  logic       empty_a;
  logic       overflow_a;

  logic       in_new_byte_b = 1'b0;
  logic [7:0] in_byte_b = 8'h00;
  logic       in_ready_b;
  logic       tx_ready_b;
  logic       tx_new_byte_b;
  logic [7:0] tx_byte_b;
  logic [7:0] count_b;
  logic       empty_b;
  logic       overflow_b;

  logic       uart_en_a = 1'b0;
  logic       uart_ready_a = 1'b1;
  logic       manual_ready_a = 1'b0;
  logic       uart_ready_b = 1'b1;

  assign tx_ready_a = uart_en_a ? uart_ready_a : manual_ready_a;
  assign tx_ready_b = uart_ready_b;

  int tests = 0;
  int errors = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int spurious_a = 0;
  int spurious_b = 0;
  int max_count_b = 0;
  logic prev_pulse_a = 1'b0;
  logic [7:0] last_byte_a = 8'h00;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];

  uart_tx_queue #(.DEPTH_LOG2(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_new_byte(in_new_byte_a), .in_byte(in_byte_a), .in_ready(in_ready_a),
    .tx_ready(tx_ready_a), .tx_new_byte(tx_new_byte_a), .tx_byte(tx_byte_a),
    .count(count_a), .empty(empty_a), .overflow(overflow_a)
  );

  uart_tx_queue #(.DEPTH_LOG2(7)) dut_b (
    .clk(clk), .rst(rst),
    .in_new_byte(in_new_byte_b), .in_byte(in_byte_b), .in_ready(in_ready_b),
    .tx_ready(tx_ready_b), .tx_new_byte(tx_new_byte_b), .tx_byte(tx_byte_b),
    .count(count_b), .empty(empty_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors: every pulse pops the oldest expected byte.
  initial forever begin
    @(negedge clk);
    if (!rst && tx_new_byte_a) begin
      check("pulse_width_a", {31'b0, prev_pulse_a}, 32'h0);
      pulses_a++;
      last_byte_a = tx_byte_a;
      if (sb_a.size() == 0) spurious_a++;
      else check("tx_byte_a", {24'b0, tx_byte_a}, {24'b0, sb_a.pop_front()});
    end
    prev_pulse_a = tx_new_byte_a;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (int'(count_b) > max_count_b) max_count_b = int'(count_b);
      if (tx_new_byte_b) begin
        pulses_b++;
        if (sb_b.size() == 0) spurious_b++;
        else check("tx_byte_b", {24'b0, tx_byte_b}, {24'b0, sb_b.pop_front()});
      end
    end
  end

  // UART models: ready drops for 10 cycles after each accepted byte.
  initial forever begin
    @(negedge clk);
    if (uart_en_a && tx_new_byte_a) begin
      uart_ready_a = 1'b0;
      repeat (10) @(negedge clk);
      uart_ready_a = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_new_byte_b) begin
      uart_ready_b = 1'b0;
      repeat (10) @(negedge clk);
      uart_ready_b = 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_a.delete();
  endtask

  task automatic wait_drain_a(input int budget);
    int n = 0;
    while (sb_a.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_a_done", sb_a.size(), 0);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_count", {27'b0, count_a}, 32'd0);
    check("rst_empty", {31'b0, empty_a}, 32'd1);
    check("rst_in_ready", {31'b0, in_ready_a}, 32'd1);
    check("rst_tx_new_byte", {31'b0, tx_new_byte_a}, 32'd0);
    check("rst_tx_byte", {24'b0, tx_byte_a}, 32'h00);
    check("rst_overflow", {31'b0, overflow_a}, 32'd0);

    // Single byte, two-cycle latency, then parked in ACKWAIT
    manual_ready_a = 1'b1;
    @(negedge clk);
    in_new_byte_a = 1'b1; in_byte_a = 8'hA1; sb_a.push_back(8'hA1);
    @(negedge clk);
    in_new_byte_a = 1'b0;
    check("lat_count_1", {27'b0, count_a}, 32'd1);
    check("lat_no_pulse_yet", {31'b0, tx_new_byte_a}, 32'd0);
    @(negedge clk);
    check("lat_pulse", {31'b0, tx_new_byte_a}, 32'd1);
    check("lat_byte", {24'b0, tx_byte_a}, 32'hA1);
    check("lat_count_0", {27'b0, count_a}, 32'd0);
    check("lat_empty", {31'b0, empty_a}, 32'd1);
    repeat (6) @(negedge clk);
    check("single_pulse_count", pulses_a, 1);
    manual_ready_a = 1'b0;
    repeat (2) @(negedge clk);
    check("tx_byte_held", {24'b0, tx_byte_a}, 32'hA1);

    // Burst of 16, then a dropped 17th byte
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_new_byte_a = 1'b1; in_byte_a = 8'(i); sb_a.push_back(8'(i));
    end
    @(negedge clk);
    check("full_count", {27'b0, count_a}, 32'd16);
    check("full_in_ready", {31'b0, in_ready_a}, 32'd0);
    check("full_no_overflow", {31'b0, overflow_a}, 32'd0);
    in_byte_a = 8'hFF;
    @(negedge clk);
    in_new_byte_a = 1'b0;
    check("ovf_set", {31'b0, overflow_a}, 32'd1);
    check("ovf_count", {27'b0, count_a}, 32'd16);

    // Drain through the UART model
    uart_en_a = 1'b1;
    wait_drain_a(16 * 16 + 50);
    repeat (15) @(negedge clk);
    check("drain_pulses", pulses_a, 17);
    check("drain_count", {27'b0, count_a}, 32'd0);
    check("ovf_sticky", {31'b0, overflow_a}, 32'd1);
    check("spurious_a_1", spurious_a, 0);

    // Full FIFO with simultaneous dequeue and enqueue
    uart_en_a = 1'b0; manual_ready_a = 1'b0;
    do_reset();
    check("ovf_cleared", {31'b0, overflow_a}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_new_byte_a = 1'b1; in_byte_a = 8'h10 + 8'(i); sb_a.push_back(8'h10 + 8'(i));
    end
    @(negedge clk);
    in_byte_a = 8'h55; sb_a.push_back(8'h55);
    manual_ready_a = 1'b1;
    @(negedge clk);
    in_new_byte_a = 1'b0; manual_ready_a = 1'b0;
    check("simul_count", {27'b0, count_a}, 32'd16);
    check("simul_no_overflow", {31'b0, overflow_a}, 32'd0);
    check("simul_pulse", {31'b0, tx_new_byte_a}, 32'd1);
    repeat (3) @(negedge clk);
    uart_en_a = 1'b1;
    wait_drain_a(17 * 16 + 50);
    check("simul_last_byte", {24'b0, last_byte_a}, 32'h55);
    check("simul_no_overflow_end", {31'b0, overflow_a}, 32'd0);
    repeat (15) @(negedge clk);

    // Reset while in ACKWAIT with 5 bytes queued
    uart_en_a = 1'b0; manual_ready_a = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_new_byte_a = 1'b1; in_byte_a = 8'hC0 + 8'(i); sb_a.push_back(8'hC0 + 8'(i));
    end
    @(negedge clk);
    in_new_byte_a = 1'b0;
    manual_ready_a = 1'b1;
    repeat (4) @(negedge clk);
    check("ackwait_count", {27'b0, count_a}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_a.delete();
    check("mid_rst_count", {27'b0, count_a}, 32'd0);
    check("mid_rst_empty", {31'b0, empty_a}, 32'd1);
    check("mid_rst_pulse", {31'b0, tx_new_byte_a}, 32'd0);
    base = pulses_a;
    repeat (12) @(negedge clk);
    check("mid_rst_no_pulses", pulses_a, base);
    manual_ready_a = 1'b0;

    // Controller-style 92-byte dump into the deep FIFO
    for (int i = 0; i < 92; i++) begin
      @(negedge clk);
      in_new_byte_b = 1'b1; in_byte_b = 8'((i * 37 + 5) & 8'hFF);
      sb_b.push_back(8'((i * 37 + 5) & 8'hFF));
      @(negedge clk);
      in_new_byte_b = 1'b0;
      @(negedge clk);
    end
    begin
      int n = 0;
      while (sb_b.size() != 0 && n < 92 * 16) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (15) @(negedge clk);
    check("dump_drained", sb_b.size(), 0);
    check("dump_pulses", pulses_b, 92);
    check("dump_overflow", {31'b0, overflow_b}, 32'd0);
    check("dump_max_count_le_92", {31'b0, max_count_b <= 92}, 32'd1);
    check("dump_queued", {31'b0, max_count_b > 1}, 32'd1);
    check("dump_empty", {31'b0, empty_b}, 32'd1);
    check("spurious_a", spurious_a, 0);
    check("spurious_b", spurious_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
